// File: rtl/uart8_receiver.sv
// 8N1 UART receiver, 16x oversampled. Start bits are detected on a falling rx
// edge; data and stop bits are sampled at mid-bit.
module uart8_receiver (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       in,
    output logic [7:0] out,
    output logic       done,
    output logic       err,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA_BITS = 2'd2,
        STOP_BIT  = 2'd3
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic [2:0] idx;
    logic [7:0] shift;

    logic       sync1;
    logic       rx_s;
    logic       rx_p;
    logic [1:0] fill;
    logic       armed;
    logic       start_edge;

    // The synchronizer resets to 1, so its first outputs after reset are not
    // the real line. armed is set only once rx_s has really been seen high, so
    // a line held low across reset release cannot fake a start edge.
    assign start_edge = armed & rx_p & ~rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
            rx_p  <= 1'b1;
            fill  <= 2'd0;
            armed <= 1'b0;
            state <= IDLE;
            cnt   <= 4'd0;
            idx   <= 3'd0;
            shift <= 8'h00;
            out   <= 8'h00;
            done  <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            sync1 <= in;
            rx_s  <= sync1;
            rx_p  <= rx_s;
            if (fill != 2'd2) begin
                fill <= fill + 2'd1;
            end else if (rx_s) begin
                armed <= 1'b1;
            end

            done <= 1'b0;
            err  <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= 4'd0;
                    idx <= 3'd0;
                    if (en && start_edge) begin
                        state <= START_BIT;
                        busy  <= 1'b1;
                    end else begin
                        busy  <= 1'b0;
                    end
                end

                START_BIT: begin
                    if (cnt == 4'd7) begin
                        cnt <= 4'd0;
                        if (!rx_s) begin
                            state <= DATA_BITS;
                        end else begin
                            // Line went back high before mid start bit: glitch.
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end

                DATA_BITS: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        shift[idx] <= rx_s;
                        if (idx == 3'd7) begin
                            state <= STOP_BIT;
                            cnt   <= 4'd0;
                            idx   <= 3'd0;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end

                STOP_BIT: begin
                    if (cnt == 4'd15) begin
                        // busy stays high for this one cycle so it overlaps
                        // the done/err pulse; IDLE clears it next cycle.
                        state <= IDLE;
                        cnt   <= 4'd0;
                        if (rx_s) begin
                            out  <= shift;
                            done <= 1'b1;
                        end else begin
                            err  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                    idx   <= 3'd0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
